mips_bus_arbiter: RTL and testbench

- Parametrised Avalon-MM bus master that lets NUM_CH requesters (e.g. fetch, data, debug) share the one memory bus of the MIPS core.
- Each request is a single-beat read or write. Requests are arbitrated (fixed or round-robin) and handed to the bus, with waitrequest honoured.
- Read data is returned to the owning channel, byte-swapped to the core's big-endian view.
- A waitrequest timeout aborts a stalled transfer with an error response.

---
 rtl/mips_bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
// Shares the single Avalon-MM memory bus of the MIPS core between NUM_CH
// requesters (fetch, data, debug, ...). Each request is one beat, read or
// write. Requests are granted by fixed priority or round-robin, presented on
// the bus until waitrequest drops, and answered with a one-cycle response to
// the owning channel. An optional waitrequest timeout turns a stalled
// transfer into an error response.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   req_valid/write  per-channel request strobe and direction (1 = write)
//   req_addr         per-channel byte address, slice [i*ADDR_W +: ADDR_W]
//   req_wdata        per-channel big-endian write data
//   req_byteen       per-channel byte enables in bus lane order
//   req_ready        one-hot accept pulse (combinational, IDLE only)
//   resp_valid/ch    response pulse and owning channel
//   resp_rdata       big-endian read data, 0 for writes and errors
//   resp_err         response is a timeout abort
//   busy             a transfer is in progress
//   address, read, write, waitrequest, writedata, byteenable, readdata
//                    Avalon-MM master interface (little-endian lanes)
module mips_bus_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int SWAP_EN = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CH-1:0]                           req_valid,
  input  logic [NUM_CH-1:0]                           req_write,
  input  logic [NUM_CH*ADDR_W-1:0]                    req_addr,
  input  logic [NUM_CH*DATA_W-1:0]                    req_wdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0]                req_byteen,
  output logic [NUM_CH-1:0]                           req_ready,
  output logic                                        resp_valid,
  output logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0] resp_ch,
  output logic [DATA_W-1:0]                           resp_rdata,
  output logic                                        resp_err,
  output logic                                        busy,
  output logic [ADDR_W-1:0]                           address,
  output logic                                        read,
  output logic                                        write,
  input  logic                                        waitrequest,
  output logic [DATA_W-1:0]                           writedata,
  output logic [DATA_W/8-1:0]                         byteenable,
  input  logic [DATA_W-1:0]                           readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int CH_W  = $clog2((NUM_CH > 1) ? NUM_CH : 2);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_BUS, S_RDATA, S_WACK, S_ERR} state_t;

  state_t              state_q;
  logic                wr_q;
  logic [CH_W-1:0]     g_q;
  logic [CH_W-1:0]     ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   address_q;
  logic [DATA_W-1:0]   writedata_q;
  logic [BE_W-1:0]     byteenable_q;
  logic                read_q;
  logic                write_q;

  logic [CH_W-1:0]     grant_d;
  logic                any_req;
  int                  idx;

  // Per-channel views of the flattened request buses.
  logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
  logic [DATA_W-1:0]   wdata_arr [NUM_CH];
  logic [BE_W-1:0]     be_arr    [NUM_CH];
  logic [DATA_W-1:0]   wdata_sel;
  logic [DATA_W-1:0]   wdata_swap;
  logic [DATA_W-1:0]   rdata_swap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign be_arr[gi]    = req_byteen[gi*BE_W +: BE_W];
    end

    // Byte k of the result takes byte BE_W-1-k of the source when swapping.
    for (gi = 0; gi < BE_W; gi++) begin : g_swap
      if (SWAP_EN != 0) begin : g_rev
        assign wdata_swap[gi*8 +: 8] = wdata_sel[(BE_W-1-gi)*8 +: 8];
        assign rdata_swap[gi*8 +: 8] = readdata[(BE_W-1-gi)*8 +: 8];
      end else begin : g_pass
        assign wdata_swap[gi*8 +: 8] = wdata_sel[gi*8 +: 8];
        assign rdata_swap[gi*8 +: 8] = readdata[gi*8 +: 8];
      end
    end
  endgenerate

  assign wdata_sel = wdata_arr[grant_d];

  // Scan channels in priority order: 0..NUM_CH-1 in fixed mode, or starting
  // just after the last winner in round-robin mode. First hit wins.
  always_comb begin
    grant_d = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) begin
        idx = (int'(ptr_q) + k + 1) % NUM_CH;
      end else begin
        idx = k;
      end
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        grant_d = CH_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && any_req && !reset) begin
      req_ready[grant_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      g_q          <= '0;
      ptr_q        <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            wr_q         <= req_write[grant_d];
            g_q          <= grant_d;
            address_q    <= addr_arr[grant_d] & ADDR_MASK;
            writedata_q  <= wdata_swap;
            byteenable_q <= be_arr[grant_d];
            read_q       <= !req_write[grant_d];
            write_q      <= req_write[grant_d];
            cnt_q        <= '0;
            if (RR_MODE != 0) begin
              ptr_q <= grant_d;
            end
            state_q <= S_BUS;
          end
        end
        S_BUS: begin
          if (waitrequest) begin
            // The cycle that sees waitrequest with cnt == TIMEOUT-1 is the
            // TIMEOUT-th stalled cycle, so the strobe lasts TIMEOUT cycles.
            if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
              read_q  <= 1'b0;
              write_q <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_ERR;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= wr_q ? S_WACK : S_RDATA;
          end
        end
        S_ERR: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        S_RDATA, S_WACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign busy       = (state_q != S_IDLE);

  // Responses are decoded from state; readdata is sampled live in RDATA,
  // which is the cycle after the bus accepted the read.
  assign resp_valid = (state_q == S_RDATA) || (state_q == S_WACK) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR);
  assign resp_ch    = g_q;
  assign resp_rdata = (state_q == S_RDATA) ? rdata_swap : '0;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: a two-channel fixed-priority instance with a
// timeout of 4 is driven from a per-cycle vector table; a three-channel
// round-robin instance without swapping is exercised by a grant-order loop.
module tb_mips_bus_arbiter;

  localparam logic [31:0] WIN0 = 32'h01234567;
  localparam logic [31:0] WIN1 = 32'hAABBCCDD;
  localparam logic [31:0] W0   = 32'h67452301;  // WIN0 byte-reversed
  localparam logic [31:0] W1   = 32'hDDCCBBAA;  // WIN1 byte-reversed

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: NUM_CH=2, fixed priority, swap on, TIMEOUT=4
  logic [1:0]  a_valid = '0, a_write = '0, a_ready;
  logic [31:0] a_a0 = '0, a_a1 = '0;
  logic        a_rv, a_rch, a_rerr, a_busy, a_rd, a_wr, a_wreq = 1'b0;
  logic [31:0] a_rdo, a_adr, a_wdo, a_rdat = '0;
  logic [3:0]  a_beo;

  mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .SWAP_EN(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_write(a_write), .req_addr({a_a1, a_a0}),
    .req_wdata({WIN1, WIN0}), .req_byteen({4'b0011, 4'b1111}),
    .req_ready(a_ready), .resp_valid(a_rv), .resp_ch(a_rch), .resp_rdata(a_rdo),
    .resp_err(a_rerr), .busy(a_busy), .address(a_adr), .read(a_rd), .write(a_wr),
    .waitrequest(a_wreq), .writedata(a_wdo), .byteenable(a_beo), .readdata(a_rdat)
  );

  // Instance B: NUM_CH=3, round-robin, swap off, no timeout
  logic [2:0]  b_valid = '0, b_write = '0, b_ready;
  logic        b_rv, b_rerr, b_busy, b_rd, b_wr;
  logic [1:0]  b_rch;
  logic [31:0] b_rdo, b_adr, b_wdo;
  logic [3:0]  b_beo;

  mips_bus_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .SWAP_EN(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_write(b_write),
    .req_addr({32'h0000_0030, 32'h0000_0020, 32'h0000_0010}),
    .req_wdata({32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000}),
    .req_byteen({4'b0100, 4'b0010, 4'b0001}),
    .req_ready(b_ready), .resp_valid(b_rv), .resp_ch(b_rch), .resp_rdata(b_rdo),
    .resp_err(b_rerr), .busy(b_busy), .address(b_adr), .read(b_rd), .write(b_wr),
    .waitrequest(1'b0), .writedata(b_wdo), .byteenable(b_beo), .readdata(32'h0)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  vld, wr;
    logic [31:0] a0, a1;
    logic        wreq;
    logic [31:0] rdat;
    logic [1:0]  rdy;
    logic        rd, wro;
    logic [31:0] adr, wdo;
    logic [3:0]  beo;
    logic        rv, rch;
    logic [31:0] rdo;
    logic        rerr, busy, rchk;
  } vec_t;

  vec_t tbl [40];
  int   nv = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic add(input logic rst, input logic [1:0] vld, input logic [1:0] wr,
                     input logic [31:0] a0, input logic [31:0] a1, input logic wreq,
                     input logic [31:0] rdat, input logic [1:0] rdy, input logic rd,
                     input logic wro, input logic [31:0] adr, input logic [31:0] wdo,
                     input logic [3:0] beo, input logic rv, input logic rch,
                     input logic [31:0] rdo, input logic rerr, input logic busy,
                     input logic rchk);
    tbl[nv] = '{rst, vld, wr, a0, a1, wreq, rdat, rdy, rd, wro, adr, wdo, beo,
                rv, rch, rdo, rerr, busy, rchk};
    nv++;
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL v%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //  rst vld    wr     a0            a1            wq rdat          rdy   rd wr adr           wdo  beo    rv ch rdo           er bsy rchk
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 1); // 0 reset state
    add(0, 2'b01, 2'b00, 32'hBFC00002, 32'h0,        0, 32'h0,        2'b01, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 1 ch0 read
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 1, 0, 32'hBFC00000, W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 2 bus
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h78563412, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 1, 0, 32'h12345678, 0, 1, 0); // 3 resp
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 4 idle
    add(0, 2'b10, 2'b10, 32'h0,        32'h00001007, 0, 32'h0,        2'b10, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 5 ch1 write
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 0, 1, 32'h00001004, W1,    4'h3, 0, 0, 32'h0,        0, 1, 0); // 6 stall 1
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 0, 1, 32'h00001004, W1,    4'h3, 0, 0, 32'h0,        0, 1, 0); // 7 stall 2
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 0, 1, 32'h00001004, W1,    4'h3, 0, 0, 32'h0,        0, 1, 0); // 8 stall 3
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 0, 1, 32'h00001004, W1,    4'h3, 0, 0, 32'h0,        0, 1, 0); // 9 accepted
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 1, 1, 32'h0,        0, 1, 0); // 10 wack
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 11 idle
    add(0, 2'b11, 2'b00, 32'h100,      32'h200,      0, 32'h0,        2'b01, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 12 both, ch0 wins
    add(0, 2'b11, 2'b00, 32'h100,      32'h200,      0, 32'h0,        2'b00, 1, 0, 32'h100,      W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 13
    add(0, 2'b11, 2'b00, 32'h100,      32'h200,      0, 32'h11223344, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 1, 0, 32'h44332211, 0, 1, 0); // 14
    add(0, 2'b11, 2'b00, 32'h100,      32'h200,      0, 32'h0,        2'b01, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 15 ch0 again
    add(0, 2'b10, 2'b00, 32'h100,      32'h200,      0, 32'h0,        2'b00, 1, 0, 32'h100,      W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 16
    add(0, 2'b10, 2'b00, 32'h100,      32'h200,      0, 32'hCAFEF00D, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 1, 0, 32'h0DF0FECA, 0, 1, 0); // 17
    add(0, 2'b10, 2'b00, 32'h100,      32'h200,      0, 32'h0,        2'b10, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 18 ch1 finally
    add(0, 2'b00, 2'b00, 32'h100,      32'h200,      0, 32'h0,        2'b00, 1, 0, 32'h200,      W1,    4'h3, 0, 0, 32'h0,        0, 1, 0); // 19
    add(0, 2'b00, 2'b00, 32'h100,      32'h200,      0, 32'hA1B2C3D4, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 1, 1, 32'hD4C3B2A1, 0, 1, 0); // 20
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 21 idle
    add(0, 2'b01, 2'b00, 32'h300,      32'h0,        1, 32'h0,        2'b01, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 22 timeout read
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 1, 0, 32'h300,      W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 23
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 1, 0, 32'h300,      W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 24
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 1, 0, 32'h300,      W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 25
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 1, 0, 32'h300,      W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 26
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'hDEADBEEF, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 1, 0, 32'h0,        1, 1, 0); // 27 err
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 28 idle
    add(0, 2'b10, 2'b00, 32'h0,        32'h400,      1, 32'h0,        2'b10, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 29 ch1 read
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 1, 0, 32'h400,      W1,    4'h3, 0, 0, 32'h0,        0, 1, 0); // 30 stall
    add(1, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 1, 0, 32'h400,      W1,    4'h3, 0, 0, 32'h0,        0, 1, 0); // 31 reset raised
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        1, 32'h0,        2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 1); // 32 after reset
    add(0, 2'b01, 2'b00, 32'h500,      32'h0,        0, 32'h0,        2'b01, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 33 fresh read
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 1, 0, 32'h500,      W0,    4'hF, 0, 0, 32'h0,        0, 1, 0); // 34
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h01020304, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 1, 0, 32'h04030201, 0, 1, 0); // 35
    add(0, 2'b00, 2'b00, 32'h0,        32'h0,        0, 32'h0,        2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 0, 0, 32'h0,        0, 0, 0); // 36 idle

    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < nv; i++) begin
      @(posedge clk);
      #1;
      reset   = tbl[i].rst;
      a_valid = tbl[i].vld;
      a_write = tbl[i].wr;
      a_a0    = tbl[i].a0;
      a_a1    = tbl[i].a1;
      a_wreq  = tbl[i].wreq;
      a_rdat  = tbl[i].rdat;
      @(negedge clk);
      n_vec++;
      chk("req_ready",  i, 32'(a_ready), 32'(tbl[i].rdy));
      chk("read",       i, 32'(a_rd),    32'(tbl[i].rd));
      chk("write",      i, 32'(a_wr),    32'(tbl[i].wro));
      chk("resp_valid", i, 32'(a_rv),    32'(tbl[i].rv));
      chk("busy",       i, 32'(a_busy),  32'(tbl[i].busy));
      if (tbl[i].rd || tbl[i].wro || tbl[i].rchk) begin
        chk("address",    i, a_adr,        tbl[i].adr);
        chk("writedata",  i, a_wdo,        tbl[i].wdo);
        chk("byteenable", i, 32'(a_beo),   32'(tbl[i].beo));
      end
      if (tbl[i].rv || tbl[i].rchk) begin
        chk("resp_ch",    i, 32'(a_rch),   32'(tbl[i].rch));
        chk("resp_rdata", i, a_rdo,        tbl[i].rdo);
        chk("resp_err",   i, 32'(a_rerr),  32'(tbl[i].rerr));
      end
      $display("vec %0d: rdy=%b rd=%b wr=%b adr=%h rv=%b ch=%0d rdata=%h err=%b busy=%b",
               i, a_ready, a_rd, a_wr, a_adr, a_rv, a_rch, a_rdo, a_rerr, a_busy);
    end

    // Round-robin: three channels writing continuously must rotate 0,1,2,0,1,2.
    @(posedge clk);
    #1;
    b_valid = 3'b111;
    b_write = 3'b111;
    for (int g = 0; g < 6; g++) begin
      int  exp_ch;
      int  waited;
      bit  seen;
      exp_ch = g % 3;
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 8) begin
        @(negedge clk);
        if (b_ready != 3'b000) seen = 1'b1;
        else waited++;
      end
      n_vec++;
      if (!seen) begin
        n_miss++;
        $display("FAIL rr_grant %0d: got no req_ready within 8 cycles, expected channel %0d", g, exp_ch);
      end else begin
        chk("rr_ready", 100 + g, 32'(b_ready), 32'(1) << exp_ch);
        @(negedge clk);
        chk("rr_write",      100 + g, 32'(b_wr),  32'd1);
        chk("rr_address",    100 + g, b_adr,      32'h10 * (exp_ch + 1));
        chk("rr_writedata",  100 + g, b_wdo,      32'hA0A0_0000 + 32'h1010_0001 * exp_ch);
        chk("rr_byteenable", 100 + g, 32'(b_beo), 32'(1) << exp_ch);
        @(negedge clk);
        chk("rr_resp_valid", 100 + g, 32'(b_rv),  32'd1);
        chk("rr_resp_ch",    100 + g, 32'(b_rch), exp_ch);
        chk("rr_resp_err",   100 + g, 32'(b_rerr), 32'd0);
        $display("rr grant %0d: ready=%b ch=%0d wdata=%h", g, b_ready, b_rch, b_wdo);
      end
    end
    b_valid = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
